dcc_bit_encoder: RTL and testbench
==================================

// Module: dcc_bit_encoder
// PURPOSE
//  Consumes the tick strobe from the DCC clock generator and a byte stream of
//  command bytes. Emits the DCC track waveform: preamble, start bits, data
//  bytes, auto-computed XOR checksum byte, and packet end bit. Sends continuous
//  '1' bits (idle preamble) whenever no packet is pending. Drives the booster
//  H-bridge inputs directly.
// PARAMETERS
//  ONE_HALF_TICKS   58  ticks per half-bit of a '1' (58 us at 1 us tick)
//  ZERO_HALF_TICKS  100 ticks per half-bit of a '0'
//  PREAMBLE_BITS    14  minimum consecutive '1' bits before a start bit
//  MAX_DATA_BYTES   5   data bytes per packet, checksum excluded
// PORTS
//  clk         in   1  system clock
//  reset_n     in   1  async active-low reset
//  tick        in   1  one-clk timebase strobe from dcc clock generator
//  byte_valid  in   1  byte_data/byte_last valid
//  byte_data   in   8  packet data byte, sent MSB first
//  byte_last   in   1  marks final data byte of packet
//  byte_ready  out  1  byte accepted this cycle (transfer = valid & ready)
//  dcc_p       out  1  track output A
//  dcc_n       out  1  track output B, always ~dcc_p
//  busy        out  1  1 from first start bit through end bit
//  err         out  1  one-clk pulse: underrun or length overflow
// BEHAVIOUR
//  Clock/reset: one clock, clk; reset_n asynchronous, active-low. On reset:
//   state IDLE, current bit '1', first half, half counter 0, preamble
//   count 0, dcc_p=1, dcc_n=0, byte_ready=0, busy=0, err=0.
//  Bit timing: half counter advances only on tick. Half ends on tick with
//   count == HALF-1, where HALF = ONE_HALF_TICKS or ZERO_HALF_TICKS per
//   current bit. End of first half: dcc_p<=0. End of second half = bit
//   boundary: next bit loads, dcc_p<=1, count<=0. Every bit is high then low.
//  Boundary decisions (all bit selection happens at a bit boundary):
//   IDLE: preamble count (saturating) +1 per '1' completed. If byte_valid and
//    count>=PREAMBLE_BITS: accept byte, next bit '0' (start), go DATA,
//    checksum<=byte, nbytes<=1, busy<=1. Else next bit '1'.
//   DATA: shift 8 bits MSB first. After bit 8:
//    last flag set -> '0', go CHK.
//    else byte_valid -> accept, '0', checksum^=byte, nbytes+1.
//    else underrun -> err pulse, '1', go IDLE.
//   Overflow: nbytes==MAX_DATA_BYTES and last flag clear -> err pulse, '0',
//    go CHK. Packet is truncated and checksum still correct for bytes sent.
//   CHK: 8 checksum bits MSB first, then '1' end bit, go IDLE, busy<=0.
//    End bit counts as preamble bit 1.
//   Any error forces IDLE with preamble count restarted at 1.
//  Handshake: byte_ready is combinational. It is high only in the boundary
//   cycle (tick, second half, count==HALF-1) where the FSM can take a byte.
//   Byte and last flag are latched on transfer. byte_data is don't-care
//   when byte_valid=0. byte_valid may drop without a transfer.
//  Reset mid-packet aborts immediately to reset values; no end bit is sent.
//  tick held high is legal and gives one count per clk.
// TESTING
//  (params 2/4/14/5, tick=1 every clk)
//  1 Idle: no byte_valid for 200 clks -> dcc_p toggles every 2 clks,
//    byte_ready never 1, busy 0.
//  2 Packet 0x03, 0x3F(last), valid from reset -> first start bit after
//    exactly 14 ones. Stream 0 00000011 0 00111111 0 00111100 1.
//    Two byte_ready pulses.
//  3 Underrun: 0x03 not last, then valid=0 -> after 8th bit: err pulse,
//    '1', busy 0. Next packet needs 13 further ones.
//  4 Overflow: 6 bytes none last -> after 5th byte: err pulse, '0'+XOR
//    of 5 bytes+'1'. 6th byte not accepted until the next preamble is done.
//  5 Reset asserted mid-data-bit -> dcc_p=1, busy=0 same instant.
//    Resume gives 14 ones before the start bit.
//  6 Timing: '0' bit measures 4+4 clks, '1' bit 2+2 clks.
//    dcc_n==~dcc_p every cycle.

Source files
------------

// File: rtl/dcc_bit_encoder.sv
// DCC track waveform encoder: idle preamble, framed data bytes, XOR checksum and end bit.
// Each bit is a high half followed by a low half; bit length is chosen by the bit value.
module dcc_bit_encoder #(
  parameter int unsigned ONE_HALF_TICKS  = 58,
  parameter int unsigned ZERO_HALF_TICKS = 100,
  parameter int unsigned PREAMBLE_BITS   = 14,
  parameter int unsigned MAX_DATA_BYTES  = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  input  logic       byte_last,
  output logic       byte_ready,
  output logic       dcc_p,
  output logic       dcc_n,
  output logic       busy,
  output logic       err
);

  localparam int unsigned MaxHalf = (ONE_HALF_TICKS > ZERO_HALF_TICKS) ?
                                    ONE_HALF_TICKS : ZERO_HALF_TICKS;
  localparam int unsigned CntW = (MaxHalf > 1) ? $clog2(MaxHalf) : 1;
  localparam int unsigned PreW = $clog2(PREAMBLE_BITS + 1);
  localparam int unsigned NbW  = $clog2(MAX_DATA_BYTES + 1);

  localparam logic [CntW-1:0] OneLast  = CntW'(ONE_HALF_TICKS - 1);
  localparam logic [CntW-1:0] ZeroLast = CntW'(ZERO_HALF_TICKS - 1);
  localparam logic [PreW-1:0] PreMax   = PreW'(PREAMBLE_BITS);
  localparam logic [NbW-1:0]  NbMax    = NbW'(MAX_DATA_BYTES);

  typedef enum logic [1:0] {StIdle, StData, StChk} state_e;

  state_e          state_q, state_d;
  logic            bit_q, bit_d;
  logic            half_q, half_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [PreW-1:0] pre_q, pre_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [3:0]      idx_q, idx_d;
  logic            last_q, last_d;
  logic [7:0]      chk_q, chk_d;
  logic [NbW-1:0]  nb_q, nb_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;
  logic            dcc_p_q, dcc_p_d;

  logic            half_end;
  logic            boundary;
  logic [PreW-1:0] pre_inc;
  logic            can_take;

  assign half_end = tick && (cnt_q == (bit_q ? OneLast : ZeroLast));
  assign boundary = half_end && half_q;
  // The '1' now completing already counts towards the preamble.
  assign pre_inc  = (bit_q && (pre_q != PreMax)) ? pre_q + 1'b1 : pre_q;
  assign can_take = ((state_q == StIdle) && (pre_inc >= PreMax)) ||
                    ((state_q == StData) && (idx_q == 4'd8) && !last_q && (nb_q != NbMax));
  assign byte_ready = boundary && can_take && byte_valid;

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    half_d  = half_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    last_d  = last_q;
    chk_d   = chk_q;
    nb_d    = nb_q;
    busy_d  = busy_q;
    err_d   = 1'b0;
    dcc_p_d = dcc_p_q;

    if (tick) begin
      if (!half_end) begin
        cnt_d = cnt_q + 1'b1;
      end else if (!half_q) begin
        cnt_d   = '0;
        half_d  = 1'b1;
        dcc_p_d = 1'b0;
      end else begin
        cnt_d   = '0;
        half_d  = 1'b0;
        dcc_p_d = 1'b1;
        unique case (state_q)
          StIdle: begin
            pre_d = pre_inc;
            if (byte_ready) begin
              bit_d   = 1'b0;
              state_d = StData;
              chk_d   = byte_data;
              shreg_d = byte_data;
              last_d  = byte_last;
              nb_d    = NbW'(1);
              idx_d   = '0;
              busy_d  = 1'b1;
            end else begin
              bit_d = 1'b1;
            end
          end
          StData: begin
            if (idx_q != 4'd8) begin
              bit_d   = shreg_q[7];
              shreg_d = {shreg_q[6:0], 1'b0};
              idx_d   = idx_q + 4'd1;
            end else if (last_q || (nb_q == NbMax)) begin
              // Overflow truncates the packet but still closes it with a valid checksum.
              err_d   = !last_q;
              bit_d   = 1'b0;
              state_d = StChk;
              shreg_d = chk_q;
              idx_d   = '0;
            end else if (byte_valid) begin
              bit_d   = 1'b0;
              chk_d   = chk_q ^ byte_data;
              shreg_d = byte_data;
              last_d  = byte_last;
              nb_d    = nb_q + 1'b1;
              idx_d   = '0;
            end else begin
              err_d   = 1'b1;
              bit_d   = 1'b1;
              state_d = StIdle;
              busy_d  = 1'b0;
              pre_d   = '0;
            end
          end
          StChk: begin
            if (idx_q != 4'd8) begin
              bit_d   = shreg_q[7];
              shreg_d = {shreg_q[6:0], 1'b0};
              idx_d   = idx_q + 4'd1;
            end else begin
              // End bit doubles as the first preamble bit of the next packet.
              bit_d   = 1'b1;
              state_d = StIdle;
              busy_d  = 1'b0;
              pre_d   = '0;
            end
          end
          default: begin
            state_d = StIdle;
            bit_d   = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      bit_q   <= 1'b1;
      half_q  <= 1'b0;
      cnt_q   <= '0;
      pre_q   <= '0;
      shreg_q <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      chk_q   <= '0;
      nb_q    <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      dcc_p_q <= 1'b1;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      half_q  <= half_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      chk_q   <= chk_d;
      nb_q    <= nb_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      dcc_p_q <= dcc_p_d;
    end
  end

  assign dcc_p = dcc_p_q;
  assign dcc_n = ~dcc_p_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule

// File: tb/tb_dcc_bit_encoder.sv
// Bench for dcc_bit_encoder: a monitor decodes track bits and pops them against a scoreboard
// queue that each test case fills from the bytes it drives.
`timescale 1ns/1ps
module tb_dcc_bit_encoder;

  localparam int unsigned OneHalf  = 2;
  localparam int unsigned ZeroHalf = 4;
  localparam int unsigned PreBits  = 14;
  localparam int unsigned MaxBytes = 5;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tick;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_last;
  logic       byte_ready;
  logic       dcc_p;
  logic       dcc_n;
  logic       busy;
  logic       err;

  always #5 clk = ~clk;

  dcc_bit_encoder #(
    .ONE_HALF_TICKS (OneHalf),
    .ZERO_HALF_TICKS(ZeroHalf),
    .PREAMBLE_BITS  (PreBits),
    .MAX_DATA_BYTES (MaxBytes)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tick      (tick),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_last (byte_last),
    .byte_ready(byte_ready),
    .dcc_p     (dcc_p),
    .dcc_n     (dcc_n),
    .busy      (busy),
    .err       (err)
  );

  typedef struct {
    string      name;
    int         n;
    logic [7:0] b [6];
    logic [5:0] last_mask;
    int         idle_bits;
    int         exp_ready;
    int         exp_err;
  } case_t;

  typedef struct {
    logic b;
    logic busy;
    logic err;
  } exp_t;

  exp_t  exp_q[$];
  case_t cases[7];
  int    checks = 0;
  int    failures = 0;
  int    ready_cnt;
  int    err_cnt;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: one bit completes at each rising edge of dcc_p.
  int   hi, lo, bit_no;
  logic in_low, err_acc, busy_acc, dec_bit;
  exp_t e_m;
  initial begin
    forever begin
      @(negedge clk);
      check("dcc_n_inv", {31'b0, dcc_n}, {31'b0, ~dcc_p});
      if (!reset_n) begin
        hi = 0; lo = 0; in_low = 1'b0; err_acc = 1'b0; busy_acc = 1'b0; bit_no = 0;
        ready_cnt = 0; err_cnt = 0;
      end else begin
        if (byte_ready) ready_cnt++;
        if (err) err_cnt++;
        if (dcc_p) begin
          if (in_low) begin
            dec_bit = (lo == OneHalf);
            check("bit_len_legal", {31'b0, (lo == OneHalf) || (lo == ZeroHalf)}, 32'd1);
            check("half_equal", hi, lo);
            if (exp_q.size() > 0) begin
              e_m = exp_q.pop_front();
              check($sformatf("bit%0d{b,busy,err}", bit_no), {29'b0, dec_bit, busy_acc, err_acc},
                    {29'b0, e_m.b, e_m.busy, e_m.err});
            end
            bit_no++;
            hi = 0; lo = 0; in_low = 1'b0; err_acc = 1'b0;
          end
          hi++;
          err_acc = err_acc | err;
        end else begin
          in_low   = 1'b1;
          lo++;
          busy_acc = busy;
          err_acc  = err_acc | err;
        end
      end
    end
  end

  task automatic push_bit(input logic b, input logic bz, input logic e);
    exp_t x;
    x.b = b; x.busy = bz; x.err = e;
    exp_q.push_back(x);
  endtask

  task automatic push_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) push_bit(v[i], 1'b1, 1'b0);
  endtask

  // Expected stream from reset, assuming valid drops once all bytes are taken.
  task automatic build_expected(input case_t c);
    int pos;
    int nb;
    logic [7:0] chk;
    logic lastf;
    bit done;
    pos = 0;
    for (int i = 0; i < PreBits; i++) push_bit(1'b1, 1'b0, 1'b0);
    while (pos < c.n) begin
      nb = 0; chk = 8'h00; done = 0;
      while (!done) begin
        push_bit(1'b0, 1'b1, 1'b0);
        push_byte(c.b[pos]);
        chk = chk ^ c.b[pos];
        lastf = c.last_mask[pos];
        nb++; pos++;
        if (lastf || nb == MaxBytes) begin
          push_bit(1'b0, 1'b1, !lastf);
          push_byte(chk);
          push_bit(1'b1, 1'b0, 1'b0);
          done = 1;
        end else if (pos >= c.n) begin
          push_bit(1'b1, 1'b0, 1'b1);
          done = 1;
        end
      end
      if (pos < c.n) for (int i = 0; i < PreBits - 1; i++) push_bit(1'b1, 1'b0, 1'b0);
    end
    for (int i = 0; i < c.idle_bits; i++) push_bit(1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    byte_valid = 1'b0; byte_last = 1'b0; byte_data = 8'h00;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("rst_dcc_p", {31'b0, dcc_p}, 32'd1);
    check("rst_dcc_n", {31'b0, dcc_n}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_ready", {31'b0, byte_ready}, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    logic got;
    byte_valid = 1'b1; byte_data = d; byte_last = l;
    got = 1'b0;
    for (int k = 0; k < 3000 && !got; k++) begin
      @(negedge clk);
      got = byte_ready;
    end
    check("ready_timeout", {31'b0, got}, 32'd1);
    @(negedge clk);
  endtask

  task automatic run_case(input case_t c);
    do_reset();
    build_expected(c);
    for (int i = 0; i < c.n; i++) send_byte(c.b[i], c.last_mask[i]);
    byte_valid = 1'b0; byte_last = 1'b0; byte_data = 8'($urandom);
    for (int k = 0; k < 6000 && exp_q.size() != 0; k++) @(negedge clk);
    check({c.name, "_drain"}, exp_q.size(), 0);
    check({c.name, "_ready_pulses"}, ready_cnt, c.exp_ready);
    check({c.name, "_err_pulses"}, err_cnt, c.exp_err);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic seen;
    tick = 1'b1;
    reset_n = 1'b0;
    byte_valid = 1'b0; byte_last = 1'b0; byte_data = 8'h00;

    cases[0] = '{name: "idle", n: 0, b: '{0, 0, 0, 0, 0, 0}, last_mask: 6'b000000,
                 idle_bits: 36, exp_ready: 0, exp_err: 0};
    cases[1] = '{name: "two_byte", n: 2, b: '{8'h03, 8'h3F, 0, 0, 0, 0},
                 last_mask: 6'b000010, idle_bits: 3, exp_ready: 2, exp_err: 0};
    cases[2] = '{name: "underrun", n: 1, b: '{8'h03, 0, 0, 0, 0, 0},
                 last_mask: 6'b000000, idle_bits: 16, exp_ready: 1, exp_err: 1};
    cases[3] = '{name: "overflow", n: 6, b: '{8'h11, 8'h22, 8'h44, 8'h88, 8'hF0, 8'h5A},
                 last_mask: 6'b000000, idle_bits: 3, exp_ready: 6, exp_err: 2};
    cases[4] = '{name: "one_byte", n: 1, b: '{8'hA5, 0, 0, 0, 0, 0},
                 last_mask: 6'b000001, idle_bits: 3, exp_ready: 1, exp_err: 0};
    cases[5] = '{name: "max_len", n: 5, b: '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 0},
                 last_mask: 6'b010000, idle_bits: 3, exp_ready: 5, exp_err: 0};
    cases[6] = '{name: "three_byte", n: 3, b: '{8'hFF, 8'h00, 8'h81, 0, 0, 0},
                 last_mask: 6'b000100, idle_bits: 3, exp_ready: 3, exp_err: 0};

    for (int i = 0; i < 7; i++) run_case(cases[i]);

    // Reset in the low half of a data bit aborts at once, then a packet follows a full preamble.
    do_reset();
    send_byte(8'h00, 1'b0);
    repeat (14) @(negedge clk);
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      seen = !dcc_p;
    end
    check("mid_pkt_low", {31'b0, seen}, 32'd1);
    check("mid_pkt_busy", {31'b0, busy}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("abort_dcc_p", {31'b0, dcc_p}, 32'd1);
    check("abort_dcc_n", {31'b0, dcc_n}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    run_case(cases[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
